cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
Shares the single physical-memory line port between the instruction-fetch cache and the data cache of the pipelined LC-3b core. It serialises misses and writebacks from both L1 caches onto one 128-bit line interface. Arbitration is round-robin on ties. The block sits between the split L1 caches (fed by the datapath's ifetch and mem ports) and physical memory / L2. A watchdog flags transactions that never complete.

Parameters:
TIMEOUT, 1023, cycles a granted transaction may wait for mem_resp before timeout_err is set; 0 disables the watchdog.
CNT_W, 10, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  icache line read request
i_address  in  16  icache line address (lc3b_word)
i_rdata  out  128  line returned to icache (lc3b_line)
i_resp  out  1  icache transaction complete
d_read  in  1  dcache line read request
d_write  in  1  dcache line write (writeback) request
d_address  in  16  dcache line address
d_wdata  in  128  dcache writeback line
d_rdata  out  128  line returned to dcache
d_resp  out  1  dcache transaction complete
mem_read  out  1  downstream read strobe
mem_write  out  1  downstream write strobe
mem_address  out  16  downstream address
mem_wdata  out  128  downstream write line
mem_rdata  in  128  downstream read line
mem_resp  in  1  downstream completion
arb_busy  out  1  a transaction is granted
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset and clocking: one clock (clk); asynchronous active-low reset (rst_n).
- Reset state (async, rst_n=0):
  - state=IDLE, last_grant=DCACHE, so the first tie goes to ICACHE.
  - Watchdog count=0, timeout_err=0.
  - All outputs 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Drives no downstream request.
  - Next state at the clock edge:
    - Only i_read asserted -> SERVE_I.
    - Only (d_read|d_write) asserted -> SERVE_D.
    - Both asserted -> grant the requester not equal to last_grant.
    - Neither -> stay IDLE.
  - Grant latency: request visible in cycle N -> downstream strobe in cycle N+1.
- SERVE_I:
  - mem_read=i_read, mem_write=0, mem_address=i_address, mem_wdata=0.
  - i_rdata=mem_rdata, i_resp=mem_resp (combinational pass-through).
- SERVE_D:
  - mem_read=d_read&~d_write, mem_write=d_write, mem_address=d_address, mem_wdata=d_wdata.
  - d_rdata=mem_rdata, d_resp=mem_resp.
  - If d_read and d_write are both asserted, the write wins.
- The non-granted requester always sees resp=0. Its rdata is 0 in IDLE and mem_rdata otherwise.
- Completion: on mem_resp=1 in SERVE_x, last_grant<=x and state<=IDLE at that edge.
- Back-to-back spacing: there is no IDLE bypass, so the earliest next downstream strobe is 2 cycles after resp.
- Requester contract: requesters deassert in the cycle after their resp. The arbiter does not filter a stale request.
- Request withdrawal: if the granted requester drops its request before mem_resp, the arbiter stays in SERVE_x with downstream strobes low. It waits for the request to reassert or for mem_resp. Requesters must not do this.
- Watchdog:
  - Count clears on entering SERVE_x and increments every cycle in SERVE_x without mem_resp.
  - When count reaches TIMEOUT, timeout_err<=1 and stays set until reset.
  - The transaction continues regardless; the count saturates.
- arb_busy = (state != IDLE).
- mem_resp asserted while in IDLE is ignored.
- Reset asserted mid-transaction: strobes drop immediately (async), the transaction is abandoned, no resp is issued, and last_grant returns to DCACHE.

Decomposition:
- Add arb_state_t enum (IDLE, SERVE_I, SERVE_D) and arb_port_t enum (ICACHE, DCACHE) to lc3b_types, next to lc3b_line and lc3b_word.
- The single module holds the FSM, the last_grant register, the output mux and the watchdog.
- No sub-module; the watchdog is about ten lines and is not reused elsewhere.

Test Plan:
- Reset release, i_read=1, i_address=16'h1230 at cycle 2 -> cycle 3: mem_read=1, mem_address=16'h1230. mem_resp at cycle 6 with mem_rdata=128'hA5..A5 -> i_resp=1 and i_rdata=A5..A5 at cycle 6; d_resp=0 throughout; arb_busy drops at cycle 7.
- i_read and d_read asserted together, first time after reset -> ICACHE granted first. After its resp, with d_read still held -> DCACHE granted 2 cycles later, mem_address = d_address.
- Both requesters held continuously across 4 transactions -> grant order I, D, I, D; each resp goes only to its owner.
- d_write=1, d_address=16'h8000, d_wdata=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 -> mem_write=1, mem_read=0, mem_wdata matches exactly. With d_read and d_write both set, the write still wins.
- TIMEOUT=8, grant SERVE_I, mem_resp withheld -> timeout_err rises on the 8th cycle of waiting and stays high. A later mem_resp still produces i_resp; timeout_err remains 1 until rst_n low.
- rst_n pulsed low during SERVE_D -> mem_read, mem_write and d_resp go to 0 immediately. After release, simultaneous requests are granted to ICACHE first.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: word/line containers and the line-port
// arbiter's state and port encodings.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_port_t;

endpackage

// File: rtl/cache_arbiter.sv
// Serialises icache and dcache line transactions onto one memory line port,
// round-robin on ties, with a sticky watchdog on stalled transactions.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_read,
    input  logic [15:0]  i_address,
    output logic [127:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_address,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [15:0]  mem_address,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_resp,
    output logic         arb_busy,
    output logic         timeout_err
);

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);
    localparam logic             WD_EN    = (TIMEOUT != 32'd0);

    arb_state_t       state_r;
    arb_state_t       next_state_s;
    arb_port_t        last_grant_r;
    logic [CNT_W-1:0] wd_count_r;
    logic             timeout_err_r;
    logic             d_req_s;
    logic             serving_s;

    assign d_req_s   = d_read | d_write;
    assign serving_s = (state_r != IDLE);

    // State and last-grant registers; completion hands the tie back to the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= DCACHE;
        end else begin
            state_r <= next_state_s;
            if (state_r == SERVE_I && mem_resp) begin
                last_grant_r <= ICACHE;
            end else if (state_r == SERVE_D && mem_resp) begin
                last_grant_r <= DCACHE;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Next-state selection: one grant per IDLE pass, no bypass on completion.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_read && d_req_s) begin
                    next_state_s = (last_grant_r == ICACHE) ? SERVE_D : SERVE_I;
                end else if (i_read) begin
                    next_state_s = SERVE_I;
                end else if (d_req_s) begin
                    next_state_s = SERVE_D;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Watchdog: counts stalled cycles of the current grant, saturating; error is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_count_r    <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if (!serving_s) begin
                wd_count_r <= {CNT_W{1'b0}};
            end else if (!mem_resp && wd_count_r != WD_LIMIT) begin
                wd_count_r <= wd_count_r + CNT_W'(1);
            end else begin
                wd_count_r <= wd_count_r;
            end
            if (WD_EN && serving_s && !mem_resp && (wd_count_r + CNT_W'(1) == WD_LIMIT)) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    // Downstream/upstream steering; responses and strobes pass through combinationally.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 16'h0000;
        mem_wdata   = 128'h0;
        i_rdata     = 128'h0;
        d_rdata     = 128'h0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (state_r)
            SERVE_I: begin
                mem_read    = i_read;
                mem_address = i_address;
                i_rdata     = mem_rdata;
                d_rdata     = mem_rdata;
                i_resp      = mem_resp;
            end
            SERVE_D: begin
                mem_read    = d_read & ~d_write;
                mem_write   = d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                i_rdata     = mem_rdata;
                d_rdata     = mem_rdata;
                d_resp      = mem_resp;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    assign arb_busy    = serving_s;
    assign timeout_err = timeout_err_r;

endmodule
